// File: rtl/mux_switch_sequencer.sv
// mux_switch_sequencer
// Break-before-make sequencer between channel requests and the mux hardware map.
// Switching order: senders off (BREAK), then new ADG1206 address (ADDR) and settle,
// then senders on (MAKE), then report the path as ready.
// Optional build macro: MUX_OVLD_BLANK_EN adds a post-switch overload blanking window
// of BLANK_CYC cycles. Without it, ovld_blank simply follows ~switching_ready.
//
// Request handshake: req_valid is a one-cycle strobe, sampled on every clock edge and
// never back-pressured. Each strobe is answered exactly one cycle later by either
// req_ack (channel in range, accepted) or req_err (channel out of range, dropped).
// Requests accepted while a switch is in progress are held in a one-deep pending
// register (last one wins) and are evaluated when the active switch completes.
module mux_switch_sequencer #(
  parameter int N_CH      = 32,
  parameter int BREAK_CYC = 4,
  parameter int ADDR_CYC  = 20,
  parameter int MAKE_CYC  = 4,
  parameter int BLANK_CYC = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [5:0] req_muxch,
  output logic [5:0] muxch_out,
  output logic       en_snd_gate,
  output logic       switching_ready,
  output logic       req_ack,
  output logic       req_err,
  output logic       ovld_blank,
  output logic [2:0] state_dbg
);

  if (BREAK_CYC < 1 || ADDR_CYC < 1 || MAKE_CYC < 1 || BLANK_CYC < 1) begin : g_param_check
    $error("mux_switch_sequencer: all *_CYC parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_BREAK = 3'd2,
    S_ADDR  = 3'd3,
    S_MAKE  = 3'd4
  } state_t;

  localparam logic [6:0]  N_CH_W     = 7'(N_CH);
  localparam logic [15:0] BREAK_LOAD = 16'(BREAK_CYC - 1);
  localparam logic [15:0] ADDR_LOAD  = 16'(ADDR_CYC - 1);
  localparam logic [15:0] MAKE_LOAD  = 16'(MAKE_CYC - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [5:0]  target;
  logic        pend_v;
  logic [5:0]  pend_ch;

  logic        req_ok;
  logic        req_bad;
  logic        idle_start;
  logic        cand_v;
  logic [5:0]  cand_ch;

  assign state_dbg = state;

  // Classify the incoming strobe and detect a switch starting from IDLE
  always_comb begin
    req_ok     = req_valid && ({1'b0, req_muxch} < N_CH_W);
    req_bad    = req_valid && !({1'b0, req_muxch} < N_CH_W);
    idle_start = (state == S_IDLE) && req_ok && (req_muxch != muxch_out);
  end

  // Candidate for the next switch at the end of MAKE: a request arriving on that
  // very edge overrides the stored pending one (last wins)
  always_comb begin
    cand_v  = pend_v;
    cand_ch = pend_ch;
    if (req_ok) begin
      cand_v  = 1'b1;
      cand_ch = req_muxch;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_INIT;
      wait_cnt        <= '0;
      target          <= '0;
      pend_v          <= 1'b0;
      pend_ch         <= '0;
      muxch_out       <= '0;
      en_snd_gate     <= 1'b0;
      switching_ready <= 1'b0;
      req_ack         <= 1'b0;
      req_err         <= 1'b0;
    end else begin
      req_ack <= req_ok;
      req_err <= req_bad;

      // Any accepted request outside IDLE is parked; the MAKE exit below may clear it
      if (req_ok && state != S_IDLE) begin
        pend_v  <= 1'b1;
        pend_ch <= req_muxch;
      end

      case (state)
        S_INIT: begin
          // Power-up path: go straight to addressing channel 0, senders are already off
          state     <= S_ADDR;
          target    <= '0;
          muxch_out <= '0;
          wait_cnt  <= ADDR_LOAD;
        end

        S_IDLE: begin
          if (idle_start) begin
            state           <= S_BREAK;
            target          <= req_muxch;
            wait_cnt        <= BREAK_LOAD;
            en_snd_gate     <= 1'b0;
            switching_ready <= 1'b0;
          end
        end

        S_BREAK: begin
          if (wait_cnt == 16'd0) begin
            state     <= S_ADDR;
            muxch_out <= target;
            wait_cnt  <= ADDR_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        S_ADDR: begin
          if (wait_cnt == 16'd0) begin
            state       <= S_MAKE;
            en_snd_gate <= 1'b1;
            wait_cnt    <= MAKE_LOAD;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        S_MAKE: begin
          if (wait_cnt == 16'd0) begin
            pend_v <= 1'b0;
            if (cand_v && cand_ch != muxch_out) begin
              // Chain straight into the next switch; ready stays low
              state       <= S_BREAK;
              target      <= cand_ch;
              wait_cnt    <= BREAK_LOAD;
              en_snd_gate <= 1'b0;
            end else begin
              state           <= S_IDLE;
              switching_ready <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

`ifdef MUX_OVLD_BLANK_EN
  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYC - 1);

  logic [15:0] blank_cnt;

  // Hold blanking through every switch and for BLANK_CYC cycles after reaching IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      ovld_blank <= 1'b1;
      blank_cnt  <= BLANK_LOAD;
    end else if (state != S_IDLE || idle_start) begin
      ovld_blank <= 1'b1;
      blank_cnt  <= BLANK_LOAD;
    end else if (blank_cnt != 16'd0) begin
      blank_cnt <= blank_cnt - 16'd1;
    end else begin
      ovld_blank <= 1'b0;
    end
  end
`else
  assign ovld_blank = ~switching_ready;
`endif

endmodule
